falafel_lsu_arbiter: RTL and testbench

- Shares the single falafel_lsu port among N_REQ requesters, for example the alloc and free sequencers.
- Arbitration is round-robin, one transaction in flight at a time.
- The arbiter is lock-aware. After a requester's LOCK completes, only that requester is granted until its UNLOCK completes. This serialises free-list critical sections.
- Sits between the requester FSMs and the LSU's core-side header interface.

---
 rtl/falafel_pkg.sv | 45 ++++
 rtl/falafel_rr_picker.sv | 28 ++
 rtl/falafel_lsu_arbiter.sv | 144 ++++++++++++++
 tb/tb_falafel_lsu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/falafel_pkg.sv
// Shared falafel types: LSU header structs, LSU op encodings and the
// arbiter state enum used by the core-side LSU arbiter.
package falafel_pkg;

   localparam int ADDR_W = 16;
   localparam int SIZE_W = 16;

   typedef enum logic [2:0] {
      LOAD                    = 3'd0,
      EDIT_SIZE_AND_NEXT_ADDR = 3'd1,
      EDIT_NEXT_ADDR          = 3'd2,
      LOCK                    = 3'd3,
      UNLOCK                  = 3'd4
   } lsu_op_e;

   typedef struct packed {
      logic [SIZE_W-1:0] size;
      logic [ADDR_W-1:0] next_addr;
      logic [ADDR_W-1:0] addr;
   } header_t;

   typedef struct packed {
      logic    val;
      lsu_op_e lsu_op;
      header_t header;
   } header_req_t;

   typedef struct packed {
      logic    val;
      header_t header;
   } header_rsp_t;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_ISSUE    = 2'd1,
      ARB_WAIT_RSP = 2'd2
   } arb_state_e;

   // Re-locking while owning would spin in the LSU; unlocking with no lock is meaningless.
   function automatic logic lock_proto_err(input lsu_op_e op, input logic held,
                                           input logic owner_match);
      return ((op == LOCK) && held && owner_match) || ((op == UNLOCK) && !held);
   endfunction

endpackage

// File: rtl/falafel_rr_picker.sv
// Combinational round-robin picker: first set bit of i_valid searching
// from i_start upward, wrapping modulo N.
module falafel_rr_picker #(
   parameter int N     = 2,
   parameter int IDX_W = 1
) (
   input  logic [N-1:0]     i_valid,
   input  logic [IDX_W-1:0] i_start,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   always_comb begin
      logic [IDX_W-1:0] v_idx;
      o_found = 1'b0;
      o_idx   = '0;
      v_idx   = '0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int k = N - 1; k >= 0; k--) begin
         v_idx = IDX_W'((int'(i_start) + k) % N);
         if (i_valid[v_idx]) begin
            o_found = 1'b1;
            o_idx   = v_idx;
         end
      end
   end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Lock-aware round-robin arbiter sharing one falafel_lsu core port among
// N_REQ requesters, one transaction in flight at a time.
module falafel_lsu_arbiter
   import falafel_pkg::*;
#(
   parameter int  N_REQ = 2,
   localparam int IDX_W = $clog2(N_REQ > 1 ? N_REQ : 2)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  header_req_t       req_header_i [N_REQ],
   output logic [N_REQ-1:0]  req_rdy_o,
   output header_rsp_t       rsp_header_o [N_REQ],
   input  logic [N_REQ-1:0]  rsp_rdy_i,
   output header_req_t       lsu_req_header_o,
   input  logic              lsu_ready_i,
   input  header_rsp_t       lsu_rsp_header_i,
   output logic              lsu_rsp_rdy_o,
   output logic              lock_held_o,
   output logic [IDX_W-1:0]  lock_owner_o,
   output logic              proto_err_o,
   output arb_state_e        arb_state_o
);

   // Handshakes: a requester holds val and header stable until req_rdy_o;
   // the LSU takes a request on lsu_ready_i in ARB_ISSUE; a response is
   // consumed when lsu_rsp_header_i.val and rsp_rdy_i[gnt] are both high.

   arb_state_e        r_state;
   logic [IDX_W-1:0]  r_rr_ptr;
   logic              r_lock_held;
   logic [IDX_W-1:0]  r_lock_owner;
   header_req_t       r_hold;
   logic [IDX_W-1:0]  r_gnt;

   logic [N_REQ-1:0]  w_eligible;
   logic              w_found;
   logic [IDX_W-1:0]  w_pick;
   logic              w_grant;
   logic              w_done;
   logic [IDX_W-1:0]  w_rr_next;
   header_req_t       w_pick_hdr;

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_eligible[i] = req_header_i[i].val &&
                         (!r_lock_held || (IDX_W'(i) == r_lock_owner));
      end
   end

   falafel_rr_picker #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .i_valid (w_eligible),
      .i_start (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   always_comb begin
      w_pick_hdr = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == w_pick) w_pick_hdr = req_header_i[i];
      end
   end

   // Reset gating keeps the combinational accept strobe quiet while held in reset.
   assign w_grant   = rst_ni && (r_state == ARB_IDLE) && w_found;
   assign w_done    = (r_state == ARB_WAIT_RSP) && lsu_rsp_header_i.val && rsp_rdy_i[r_gnt];
   assign w_rr_next = (r_gnt == IDX_W'(N_REQ - 1)) ? '0 : r_gnt + 1'b1;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state      <= ARB_IDLE;
         r_rr_ptr     <= '0;
         r_lock_held  <= 1'b0;
         r_lock_owner <= '0;
         r_hold       <= '0;
         r_gnt        <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_grant) begin
                  r_hold  <= w_pick_hdr;
                  r_gnt   <= w_pick;
                  r_state <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               if (lsu_ready_i) r_state <= ARB_WAIT_RSP;
            end
            ARB_WAIT_RSP: begin
               if (w_done) begin
                  // Lock ownership only moves when the LSU confirms the operation.
                  if (r_hold.lsu_op == LOCK) begin
                     r_lock_held  <= 1'b1;
                     r_lock_owner <= r_gnt;
                  end else if ((r_hold.lsu_op == UNLOCK) && r_lock_held &&
                               (r_gnt == r_lock_owner)) begin
                     r_lock_held <= 1'b0;
                  end
                  r_rr_ptr <= w_rr_next;
                  r_state  <= ARB_IDLE;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   always_comb begin
      req_rdy_o = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_grant && (IDX_W'(i) == w_pick)) req_rdy_o[i] = 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         rsp_header_o[i] = '0;
         if ((r_state == ARB_WAIT_RSP) && (IDX_W'(i) == r_gnt)) begin
            rsp_header_o[i] = lsu_rsp_header_i;
         end
      end
   end

   always_comb begin
      lsu_req_header_o = '0;
      if (r_state == ARB_ISSUE) begin
         lsu_req_header_o     = r_hold;
         lsu_req_header_o.val = 1'b1;
      end
   end

   assign lsu_rsp_rdy_o = (r_state == ARB_WAIT_RSP) && rsp_rdy_i[r_gnt];
   assign proto_err_o   = w_grant && lock_proto_err(w_pick_hdr.lsu_op, r_lock_held,
                                                    w_pick == r_lock_owner);
   assign lock_held_o   = r_lock_held;
   assign lock_owner_o  = r_lock_owner;
   assign arb_state_o   = r_state;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Directed plus randomized bench for falafel_lsu_arbiter against a
// queue-free behavioural model of round-robin/lock arbitration.
module tb_falafel_lsu_arbiter;
   import falafel_pkg::*;

   localparam int N = 2;

   logic          clk = 1'b0;
   logic          rst_ni;
   header_req_t   req_header_i [N];
   logic [N-1:0]  req_rdy_o;
   header_rsp_t   rsp_header_o [N];
   logic [N-1:0]  rsp_rdy_i;
   header_req_t   lsu_req_header_o;
   logic          lsu_ready_i;
   header_rsp_t   lsu_rsp_header_i;
   logic          lsu_rsp_rdy_o;
   logic          lock_held_o;
   logic [0:0]    lock_owner_o;
   logic          proto_err_o;
   arb_state_e    arb_state_o;

   falafel_lsu_arbiter #(.N_REQ(N)) dut (
      .clk_i            (clk),
      .rst_ni           (rst_ni),
      .req_header_i     (req_header_i),
      .req_rdy_o        (req_rdy_o),
      .rsp_header_o     (rsp_header_o),
      .rsp_rdy_i        (rsp_rdy_i),
      .lsu_req_header_o (lsu_req_header_o),
      .lsu_ready_i      (lsu_ready_i),
      .lsu_rsp_header_i (lsu_rsp_header_i),
      .lsu_rsp_rdy_o    (lsu_rsp_rdy_o),
      .lock_held_o      (lock_held_o),
      .lock_owner_o     (lock_owner_o),
      .proto_err_o      (proto_err_o),
      .arb_state_o      (arb_state_o)
   );

   always #5 clk = ~clk;

   int      n_chk  = 0;
   int      n_fail = 0;
   logic    p_val [N];
   lsu_op_e p_op  [N];
   header_t p_hdr [N];
   int      m_rr = 0;
   logic    m_lh = 1'b0;
   int      m_lo = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         req_header_i[i].val    = p_val[i];
         req_header_i[i].lsu_op = p_op[i];
         req_header_i[i].header = p_hdr[i];
      end
   endtask

   function automatic header_t rand_hdr();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[47:0];
   endfunction

   function automatic lsu_op_e rand_op();
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) return LOAD;
      if (r == 6) return EDIT_SIZE_AND_NEXT_ADDR;
      if (r == 7) return EDIT_NEXT_ADDR;
      if (r == 8) return LOCK;
      return UNLOCK;
   endfunction

   // Whom the rules say gets the port next: nearest valid requester at or
   // after the round-robin pointer, restricted to the lock owner if any.
   function automatic int predict();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_rr + k) % N;
         if (p_val[i] && (!m_lh || i == m_lo)) return i;
      end
      return -1;
   endfunction

   task automatic set_req(input int i, input lsu_op_e op);
      p_val[i] = 1'b1;
      p_op[i]  = op;
      p_hdr[i] = rand_hdr();
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) p_val[i] = 1'b0;
   endtask

   task automatic reset_outputs_check();
      chk("rst_req_rdy", req_rdy_o, 0);
      chk("rst_lsu_val", lsu_req_header_o.val, 0);
      for (int i = 0; i < N; i++) chk("rst_rsp_val", rsp_header_o[i].val, 0);
      chk("rst_lsu_rsp_rdy", lsu_rsp_rdy_o, 0);
      chk("rst_proto_err", proto_err_o, 0);
      chk("rst_lock_held", lock_held_o, 0);
      chk("rst_state", arb_state_o, ARB_IDLE);
   endtask

   // Entered at posedge+1 with p_* set; runs one full transaction and
   // returns at posedge+1 of the cycle after completion.
   task automatic serve(input int lsu_wait, input int rsp_hold, output int g);
      logic        exp_err;
      header_req_t h;
      header_rsp_t exp_rsp;
      logic [N-1:0] exp_rdy;
      drive_reqs();
      #4;
      chk("idle_state", arb_state_o, ARB_IDLE);
      chk("lock_held", lock_held_o, m_lh);
      if (m_lh) chk("lock_owner", lock_owner_o, m_lo);
      g = predict();
      if (g < 0) begin
         chk("eligible_exists", 0, 1);
         @(posedge clk); #1;
         return;
      end
      exp_rdy    = '0;
      exp_rdy[g] = 1'b1;
      exp_err    = (p_op[g] == LOCK && m_lh && g == m_lo) || (p_op[g] == UNLOCK && !m_lh);
      chk("req_rdy", req_rdy_o, exp_rdy);
      chk("proto_err", proto_err_o, exp_err);
      chk("accept_lsu_val", lsu_req_header_o.val, 0);
      h.val    = 1'b1;
      h.lsu_op = p_op[g];
      h.header = p_hdr[g];
      @(posedge clk); #1;
      p_val[g] = 1'b0;
      drive_reqs();
      for (int w = 0; w <= lsu_wait; w++) begin
         lsu_ready_i = (w == lsu_wait);
         #4;
         chk("issue_state", arb_state_o, ARB_ISSUE);
         chk("lsu_req", lsu_req_header_o, h);
         chk("issue_req_rdy", req_rdy_o, 0);
         chk("issue_proto_err", proto_err_o, 0);
         @(posedge clk); #1;
      end
      lsu_ready_i        = 1'($urandom_range(0, 1));
      exp_rsp.val        = 1'b1;
      exp_rsp.header     = rand_hdr();
      lsu_rsp_header_i   = exp_rsp;
      for (int c = 0; c <= rsp_hold; c++) begin
         rsp_rdy_i    = N'($urandom());
         rsp_rdy_i[g] = (c == rsp_hold);
         #4;
         chk("wait_state", arb_state_o, ARB_WAIT_RSP);
         chk("lsu_rsp_rdy", lsu_rsp_rdy_o, c == rsp_hold);
         chk("rsp_route", rsp_header_o[g], exp_rsp);
         for (int i = 0; i < N; i++) begin
            if (i != g) chk("rsp_other_val", rsp_header_o[i].val, 0);
         end
         chk("wait_lsu_val", lsu_req_header_o.val, 0);
         chk("wait_req_rdy", req_rdy_o, 0);
         chk("wait_lock_held", lock_held_o, m_lh);
         @(posedge clk); #1;
      end
      if (h.lsu_op == LOCK) begin
         m_lh = 1'b1;
         m_lo = g;
      end else if (h.lsu_op == UNLOCK && m_lh && g == m_lo) begin
         m_lh = 1'b0;
      end
      m_rr             = (g + 1) % N;
      lsu_rsp_header_i = '0;
      rsp_rdy_i        = '0;
      lsu_ready_i      = 1'b0;
   endtask

   initial begin
      int g;
      int cnt [N];
      rst_ni           = 1'b0;
      rsp_rdy_i        = '0;
      lsu_ready_i      = 1'b0;
      lsu_rsp_header_i = '0;
      clear_reqs();
      for (int i = 0; i < N; i++) begin
         p_op[i]  = LOAD;
         p_hdr[i] = '0;
         cnt[i]   = 0;
      end
      set_req(0, LOAD);
      drive_reqs();

      // Reset holds everything quiet even with a request pending.
      @(posedge clk); #1;
      #4;
      reset_outputs_check();
      @(posedge clk); #1;
      rst_ni = 1'b1;
      clear_reqs();

      // Single requester, LOAD at 0x40.
      set_req(0, LOAD);
      p_hdr[0].addr = 16'h0040;
      serve(0, 0, g);
      chk("single_gnt", g, 0);

      // Pointer moved to 1: simultaneous pair goes to requester 1 first.
      set_req(0, LOAD);
      set_req(1, LOAD);
      serve(0, 1, g);
      chk("rr_after_single", g, 1);
      clear_reqs();

      // Contention from pointer 0 over 10 rounds.
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < N; i++) if (!p_val[i]) set_req(i, LOAD);
         serve($urandom_range(0, 2), $urandom_range(0, 2), g);
         if (r == 0) chk("cont_first", g, 0);
         if (r == 1) chk("cont_second", g, 1);
         if (r == 2) chk("cont_third", g, 0);
         cnt[g]++;
      end
      chk("cont_cnt0", cnt[0], 5);
      chk("cont_cnt1", cnt[1], 5);
      clear_reqs();

      // Lock ownership by requester 1.
      set_req(1, LOCK);
      serve(0, 0, g);
      chk("lock_gnt", g, 1);
      set_req(0, LOAD);
      drive_reqs();
      for (int c = 0; c < 3; c++) begin
         #4;
         chk("lock_stall_rdy", req_rdy_o, 0);
         chk("lock_held_const", lock_held_o, 1);
         chk("lock_owner_const", lock_owner_o, 1);
         @(posedge clk); #1;
      end
      set_req(1, EDIT_NEXT_ADDR);
      serve(0, 0, g);
      chk("lock_edit_gnt", g, 1);
      set_req(1, UNLOCK);
      serve(1, 0, g);
      chk("unlock_gnt", g, 1);
      serve(0, 0, g);
      chk("post_unlock_gnt", g, 0);

      // Response backpressure for 5 cycles.
      set_req(0, LOAD);
      serve(1, 5, g);
      chk("bp_gnt", g, 0);

      // Protocol errors: stray UNLOCK, then owner re-LOCK.
      set_req(0, UNLOCK);
      serve(0, 0, g);
      set_req(0, LOCK);
      serve(0, 0, g);
      set_req(0, LOCK);
      serve(0, 0, g);
      set_req(0, UNLOCK);
      serve(0, 0, g);
      chk("err_lock_released", m_lh, lock_held_o);

      // Randomized traffic, including dropped requests and lock ops.
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_val[i] && $urandom_range(0, 1) == 1) set_req(i, rand_op());
            else if (p_val[i] && $urandom_range(0, 3) == 0 && !(m_lh && i == m_lo)) p_val[i] = 1'b0;
         end
         if (m_lh && !p_val[m_lo]) set_req(m_lo, rand_op());
         if (predict() < 0) set_req(0, rand_op());
         serve($urandom_range(0, 2), $urandom_range(0, 3), g);
      end
      clear_reqs();
      if (m_lh) begin
         set_req(m_lo, UNLOCK);
         serve(0, 0, g);
      end

      // Reset in the middle of a response wait while a lock is held.
      set_req(0, LOCK);
      serve(0, 0, g);
      set_req(0, LOAD);
      drive_reqs();
      #4;
      chk("mid_accept", req_rdy_o, 2'b01);
      @(posedge clk); #1;
      p_val[0] = 1'b0;
      drive_reqs();
      lsu_ready_i = 1'b1;
      #4;
      chk("mid_issue", arb_state_o, ARB_ISSUE);
      @(posedge clk); #1;
      lsu_ready_i          = 1'b0;
      lsu_rsp_header_i.val = 1'b1;
      lsu_rsp_header_i.header = rand_hdr();
      #4;
      chk("mid_wait", arb_state_o, ARB_WAIT_RSP);
      chk("mid_lock_held", lock_held_o, 1);
      @(posedge clk); #1;
      rst_ni = 1'b0;
      set_req(1, LOAD);
      drive_reqs();
      #4;
      chk("in_reset_rdy", req_rdy_o, 0);
      @(posedge clk); #1;
      rst_ni           = 1'b1;
      lsu_rsp_header_i = '0;
      clear_reqs();
      drive_reqs();
      m_rr = 0;
      m_lh = 1'b0;
      m_lo = 0;
      #4;
      reset_outputs_check();
      @(posedge clk); #1;
      set_req(1, LOAD);
      serve(0, 1, g);
      chk("post_reset_gnt", g, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
